fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a 16-entry direct-mapped instruction cache.
// A miss blocks in WAIT until the memory controller returns the word.
module fetch_unit (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        jump_in,
    input  logic [31:0] jump_pc_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_data_in,
    output logic [31:0] pc_out,
    output logic [31:0] instru_out,
    output logic        valid_out,
    output logic        stall_req_out
);
    // state | meaning
    // IDLE  | issue from the cache on a hit, start a line fill on a miss
    // WAIT  | fill outstanding; mem_req_out/mem_addr_out held until mem_done_in

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [15:0] line_valid;
    logic [25:0] line_tag  [16];
    logic [31:0] line_data [16];

    logic [3:0]  pc_idx;
    logic [25:0] pc_tag;
    logic        hit;
    logic [3:0]  fill_idx;
    logic        fill_en;

    assign pc_idx        = fetch_pc[5:2];
    assign pc_tag        = fetch_pc[31:6];
    assign hit           = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
    // The fill lands where the request was aimed, not where the PC points now.
    assign fill_idx      = mem_addr_out[5:2];
    assign fill_en       = rst_in && (state == WAIT) && mem_done_in;
    assign stall_req_out = (state == WAIT);

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            line_tag[fill_idx]  <= mem_addr_out[31:6];
            line_data[fill_idx] <= mem_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            fetch_pc     <= '0;
            line_valid   <= '0;
            mem_req_out  <= 1'b0;
            mem_addr_out <= '0;
            pc_out       <= '0;
            instru_out   <= '0;
            valid_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (jump_in) begin
                        fetch_pc  <= jump_pc_in;
                        valid_out <= 1'b0;
                    end else if (!stall_in) begin
                        if (hit) begin
                            pc_out     <= fetch_pc;
                            instru_out <= line_data[pc_idx];
                            valid_out  <= 1'b1;
                            fetch_pc   <= fetch_pc + 32'd4;
                        end else begin
                            mem_req_out  <= 1'b1;
                            mem_addr_out <= {fetch_pc[31:2], 2'b00};
                            valid_out    <= 1'b0;
                            state        <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A redirect does not cancel the fill; both may happen together.
                    if (mem_done_in) begin
                        line_valid[fill_idx] <= 1'b1;
                        mem_req_out          <= 1'b0;
                        state                <= IDLE;
                    end
                    if (jump_in) begin
                        fetch_pc <= jump_pc_in;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural fetch/cache model.
module tb_fetch_unit;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stall_in;
    logic        jump_in;
    logic [31:0] jump_pc_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_done_in;
    logic [31:0] mem_data_in;
    logic [31:0] pc_out;
    logic [31:0] instru_out;
    logic        valid_out;
    logic        stall_req_out;

    fetch_unit dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .stall_in     (stall_in),
        .jump_in      (jump_in),
        .jump_pc_in   (jump_pc_in),
        .mem_req_out  (mem_req_out),
        .mem_addr_out (mem_addr_out),
        .mem_done_in  (mem_done_in),
        .mem_data_in  (mem_data_in),
        .pc_out       (pc_out),
        .instru_out   (instru_out),
        .valid_out    (valid_out),
        .stall_req_out(stall_req_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // behavioural model: fetch PC, blocked-on-fill flag, outputs, cache keyed by word index
    bit          m_wait;
    bit          m_req;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_pcout;
    logic [31:0] m_instr;
    bit          c_valid [16];
    logic [31:0] c_tag   [16];
    logic [31:0] c_data  [16];

    function automatic int unsigned slot_of(input logic [31:0] a);
        return (a / 4) % 16;
    endfunction

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    task automatic model_step();
        int unsigned s;
        if (!rst_in) begin
            m_wait = 0; m_req = 0; m_valid = 0;
            m_pc = 0; m_addr = 0; m_pcout = 0; m_instr = 0;
            for (int i = 0; i < 16; i++) c_valid[i] = 0;
        end else if (!m_wait) begin
            s = slot_of(m_pc);
            if (jump_in) begin
                m_pc = jump_pc_in;
                m_valid = 0;
            end else if (stall_in) begin
                m_valid = m_valid;
            end else if (c_valid[s] && c_tag[s] == m_pc / 64) begin
                m_pcout = m_pc;
                m_instr = c_data[s];
                m_valid = 1;
                m_pc    = m_pc + 4;
            end else begin
                m_req   = 1;
                m_addr  = m_pc - (m_pc % 4);
                m_valid = 0;
                m_wait  = 1;
            end
        end else begin
            if (mem_done_in) begin
                s = slot_of(m_addr);
                c_valid[s] = 1;
                c_tag[s]   = m_addr / 64;
                c_data[s]  = mem_data_in;
                m_req  = 0;
                m_wait = 0;
            end
            if (jump_in) m_pc = jump_pc_in;
        end
    endtask

    // memory controller stand-in, driven from the model's request
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_pend = 0;
    int          mem_lat = 3;
    bit          mem_rand_lat = 0;
    bit          late_done_seen = 0;

    task automatic cycle();
        mem_done_in = 1'b0;
        mem_data_in = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                mem_done_in = 1'b1;
                mem_data_in = word_for(mem_pend);
                mem_busy = 0;
                if (!m_wait) late_done_seen = 1;
            end else begin
                mem_cnt--;
            end
        end else if (m_req) begin
            mem_busy = 1;
            mem_pend = m_addr;
            mem_cnt  = mem_rand_lat ? int'($urandom_range(0, 3)) : mem_lat - 1;
        end
        @(posedge clk_in);
        model_step();
        #1;
        check("mem_req",   {31'd0, mem_req_out},   {31'd0, m_req});
        check("mem_addr",  mem_addr_out,           m_addr);
        check("pc_out",    pc_out,                 m_pcout);
        check("instru",    instru_out,             m_instr);
        check("valid",     {31'd0, valid_out},     {31'd0, m_valid});
        check("stall_req", {31'd0, stall_req_out}, {31'd0, m_wait});
        @(negedge clk_in);
    endtask

    task automatic run_until_valid(input string tag);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (valid_out === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic run_until_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check({tag, "_novalid"}, {31'd0, valid_out}, 32'd0);
            if (stall_req_out === 1'b0) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic jump_to(input logic [31:0] target);
        jump_in = 1'b1;
        jump_pc_in = target;
        cycle();
        jump_in = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] base;
        case ($urandom_range(0, 3))
            0: base = 32'h0000_0000;
            1: base = 32'h0000_0040;
            2: base = 32'h0000_0080;
            default: base = 32'hFFFF_FFC0;
        endcase
        return base + 32'($urandom_range(0, 15) * 4);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b0; stall_in = 1'b0; jump_in = 1'b0; jump_pc_in = '0;
        mem_done_in = 1'b0; mem_data_in = '0;
        @(negedge clk_in);
        cycle();
        cycle();
        check("rst_req",   {31'd0, mem_req_out},   32'd0);
        check("rst_valid", {31'd0, valid_out},     32'd0);
        check("rst_pc",    pc_out,                 32'd0);
        check("rst_sreq",  {31'd0, stall_req_out}, 32'd0);

        // cold start
        rst_in = 1'b1;
        cycle();
        check("cold_req",  {31'd0, mem_req_out}, 32'd1);
        check("cold_addr", mem_addr_out, 32'd0);
        run_until_valid("cold");
        check("cold_pc",    pc_out,     32'd0);
        check("cold_instr", instru_out, 32'h0000_0013);
        cycle();
        check("cold_next_req",  {31'd0, mem_req_out}, 32'd1);
        check("cold_next_addr", mem_addr_out, 32'd4);
        run_until_valid("fill4");
        check("fill4_pc", pc_out, 32'd4);

        // hit loop over 0x0 and 0x4
        jump_to(32'd0);
        check("hit_jump_req", {31'd0, mem_req_out}, 32'd0);
        cycle();
        check("hit0_pc",    pc_out, 32'd0);
        check("hit0_valid", {31'd0, valid_out}, 32'd1);
        check("hit0_req",   {31'd0, mem_req_out}, 32'd0);
        cycle();
        check("hit4_pc",    pc_out, 32'd4);
        check("hit4_instr", instru_out, 32'h0000_0413);
        check("hit4_req",   {31'd0, mem_req_out}, 32'd0);
        cycle();
        check("miss8_req",  {31'd0, mem_req_out}, 32'd1);
        check("miss8_addr", mem_addr_out, 32'd8);

        // redirect while 0x8 is outstanding
        jump_to(32'h100);
        check("jw_hold_addr", mem_addr_out, 32'd8);
        run_until_idle("jw");
        cycle();
        check("jw_req",  {31'd0, mem_req_out}, 32'd1);
        check("jw_addr", mem_addr_out, 32'h100);
        run_until_idle("f100");
        jump_to(32'd8);
        cycle();
        check("e2_hit_req",   {31'd0, mem_req_out}, 32'd0);
        check("e2_hit_pc",    pc_out, 32'd8);
        check("e2_hit_instr", instru_out, 32'h0000_0813);

        // stall while issuing hits
        cycle();
        check("missC_addr", mem_addr_out, 32'hC);
        run_until_idle("fC");
        jump_to(32'd4);
        cycle();
        check("pre_stall_pc", pc_out, 32'd4);
        stall_in = 1'b1;
        repeat (3) begin
            cycle();
            check("stall_pc",    pc_out, 32'd4);
            check("stall_valid", {31'd0, valid_out}, 32'd1);
            check("stall_instr", instru_out, 32'h0000_0413);
        end
        stall_in = 1'b0;
        cycle();
        check("resume_pc",    pc_out, 32'd8);
        check("resume_valid", {31'd0, valid_out}, 32'd1);

        // index-0 conflict: 0x0, 0x40, then 0x0 again
        jump_to(32'd0);
        cycle();
        check("cf0_addr", mem_addr_out, 32'd0);
        run_until_idle("cf0");
        jump_to(32'h40);
        cycle();
        check("cf40_addr", mem_addr_out, 32'h40);
        run_until_idle("cf40");
        jump_to(32'd0);
        cycle();
        check("cf_again_req",  {31'd0, mem_req_out}, 32'd1);
        check("cf_again_addr", mem_addr_out, 32'd0);
        run_until_idle("cf2");

        // reset while a fill is outstanding; the late answer must be dropped
        jump_to(32'h80);
        cycle();
        check("rw_pre_req", {31'd0, mem_req_out}, 32'd1);
        late_done_seen = 0;
        rst_in = 1'b0;
        cycle();
        check("rw_req",   {31'd0, mem_req_out},   32'd0);
        check("rw_sreq",  {31'd0, stall_req_out}, 32'd0);
        check("rw_valid", {31'd0, valid_out},     32'd0);
        check("rw_pc",    pc_out,                 32'd0);
        check("rw_instr", instru_out,             32'd0);
        rst_in = 1'b1;
        stall_in = 1'b1;
        repeat (6) cycle();
        check("rw_late_done", {31'd0, late_done_seen}, 32'd1);
        check("rw_idle", {31'd0, stall_req_out}, 32'd0);
        stall_in = 1'b0;
        cycle();
        check("rw_miss0_req",  {31'd0, mem_req_out}, 32'd1);
        check("rw_miss0_addr", mem_addr_out, 32'd0);
        run_until_idle("rw_fill");

        // randomized traffic
        mem_rand_lat = 1;
        for (int n = 0; n < 3000; n++) begin
            rst_in     = ($urandom_range(0, 99) != 0);
            stall_in   = ($urandom_range(0, 3) == 0);
            jump_in    = ($urandom_range(0, 9) == 0);
            jump_pc_in = pick_target();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
